// File: rtl/riscv_mem_wb_stage.sv
// rtl/riscv_mem_wb_stage.sv - MEM/WB pipeline register with load alignment; optional bubble counter via RISCV_MEMWB_BUBBLE_CNT_EN
module riscv_mem_wb_stage #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [RD_W-1:0]    rd_idx_i,
    input  logic               rd_we_i,
    input  logic [XLEN-1:0]    alu_res_i,
    input  logic [XLEN-1:0]    mem_data_i,
    input  logic [XLEN-1:0]    mem_addr_i,
    input  logic               mem_re_i,
    input  logic [2:0]         funct3_i,
    output logic               valid_o,
    output logic [RD_W-1:0]    rd_idx_o,
    output logic               rd_we_o,
    output logic [XLEN-1:0]    wb_data_o,
    output logic [XLEN-1:0]    mem_addr_o,
    output logic               mem_re_o,
    output logic               lderr_o,
    output logic               fwd_valid_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam int OFF_W = $clog2(XLEN / 8);

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  shifted;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_word;
    logic [XLEN-1:0]  fmt;
    logic             err;
    logic [XLEN-1:0]  wb_next;
    logic             err_eff;
    logic             bubble;
    logic             advance;

    assign off     = mem_addr_i[OFF_W-1:0];
    assign shifted = mem_data_i >> {off, 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = shifted[15:0];
    assign ld_word = shifted[31:0];

    assign bubble  = stall[STAGE] & ~stall[STAGE+1];
    assign advance = ~stall[STAGE];

    // Decode load size/sign: select the lane at off and flag misaligned or unsupported codes
    always_comb begin
        fmt = mem_data_i;
        err = 1'b0;
        case (funct3_i)
            3'b000: fmt = XLEN'($signed(ld_byte));
            3'b100: fmt = XLEN'(ld_byte);
            3'b001: begin
                fmt = XLEN'($signed(ld_half));
                err = off[0];
            end
            3'b101: begin
                fmt = XLEN'(ld_half);
                err = off[0];
            end
            3'b010: begin
                fmt = XLEN'($signed(ld_word));
                err = (off[1:0] != 2'b00);
            end
            3'b110: begin
                // Unsigned word only exists on RV64; still requires word alignment there
                fmt = XLEN'(ld_word);
                err = (XLEN != 64) || (off[1:0] != 2'b00);
            end
            3'b011: begin
                fmt = mem_data_i;
                err = (XLEN != 64) || (off != '0);
            end
            default: begin
                fmt = mem_data_i;
                err = 1'b1;
            end
        endcase
    end

    // A faulting load writes back the raw memory word so the trap handler can inspect it
    assign err_eff = mem_re_i & err;
    assign wb_next = mem_re_i ? (err ? mem_data_i : fmt) : alu_res_i;

    // Pipeline register: rst, then flush, then bubble, then load; otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || bubble) begin
            valid_o    <= 1'b0;
            rd_idx_o   <= '0;
            rd_we_o    <= 1'b0;
            wb_data_o  <= '0;
            mem_addr_o <= '0;
            mem_re_o   <= 1'b0;
            lderr_o    <= 1'b0;
        end else if (advance) begin
            valid_o    <= valid_i;
            rd_idx_o   <= rd_idx_i;
            rd_we_o    <= valid_i & rd_we_i & (rd_idx_i != '0) & ~err_eff;
            wb_data_o  <= wb_next;
            mem_addr_o <= mem_addr_i;
            mem_re_o   <= mem_re_i;
            lderr_o    <= valid_i & err_eff;
        end
    end

    assign fwd_valid_o = valid_o & rd_we_o & (rd_idx_o != '0);

`ifdef RISCV_MEMWB_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;

    // Saturating count of bubbles; a flush takes priority and is not a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt_o = bubble_cnt;
`else
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// tb/tb_riscv_mem_wb_stage.sv - self-checking bench for riscv_mem_wb_stage
module tb_riscv_mem_wb_stage;

    localparam int XLEN    = 32;
    localparam int RD_W    = 5;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int CNT_W   = 2;
    localparam logic [31:0] D = 32'h80FF7F01;

`ifdef RISCV_MEMWB_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               valid_i;
    logic [RD_W-1:0]    rd_idx_i;
    logic               rd_we_i;
    logic [XLEN-1:0]    alu_res_i;
    logic [XLEN-1:0]    mem_data_i;
    logic [XLEN-1:0]    mem_addr_i;
    logic               mem_re_i;
    logic [2:0]         funct3_i;
    logic               valid_o;
    logic [RD_W-1:0]    rd_idx_o;
    logic               rd_we_o;
    logic [XLEN-1:0]    wb_data_o;
    logic [XLEN-1:0]    mem_addr_o;
    logic               mem_re_o;
    logic               lderr_o;
    logic               fwd_valid_o;
    logic [CNT_W-1:0]   bubble_cnt_o;

    riscv_mem_wb_stage #(
        .XLEN(XLEN), .RD_W(RD_W), .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_i(valid_i), .rd_idx_i(rd_idx_i), .rd_we_i(rd_we_i),
        .alu_res_i(alu_res_i), .mem_data_i(mem_data_i), .mem_addr_i(mem_addr_i),
        .mem_re_i(mem_re_i), .funct3_i(funct3_i),
        .valid_o(valid_o), .rd_idx_o(rd_idx_o), .rd_we_o(rd_we_o),
        .wb_data_o(wb_data_o), .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o),
        .lderr_o(lderr_o), .fwd_valid_o(fwd_valid_o), .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] addr;
        logic        re;
        logic [2:0]  f3;
        logic        e_we;
        logic [31:0] e_wb;
        logic        e_err;
        logic        e_fwd;
    } vec_t;

    vec_t vecs[17];
    int   errors = 0;
    int   checks = 0;
    int   cnt_exp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        valid_i    = v.valid;
        rd_idx_i   = v.rd;
        rd_we_i    = v.we;
        alu_res_i  = v.alu;
        mem_data_i = v.data;
        mem_addr_i = v.addr;
        mem_re_i   = v.re;
        funct3_i   = v.f3;
    endtask

    task automatic randomize_inputs();
        valid_i    = 1'($urandom);
        rd_idx_i   = 5'($urandom);
        rd_we_i    = 1'($urandom);
        alu_res_i  = $urandom;
        mem_data_i = $urandom;
        mem_addr_i = $urandom;
        mem_re_i   = 1'($urandom);
        funct3_i   = 3'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 64'(valid_o), 64'd0);
        chk({tag, ".rd_idx"}, 64'(rd_idx_o), 64'd0);
        chk({tag, ".rd_we"}, 64'(rd_we_o), 64'd0);
        chk({tag, ".wb_data"}, 64'(wb_data_o), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, ".mem_re"}, 64'(mem_re_o), 64'd0);
        chk({tag, ".lderr"}, 64'(lderr_o), 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid_o), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble_model();
        if (CNT_EN && cnt_exp < 3) cnt_exp++;
    endtask

    initial begin
        //           valid rd    we    alu           data addr          re    f3      e_we  e_wb          e_err e_fwd
        vecs[0]  = '{1'b1, 5'd5,  1'b1, 32'h1234, D, 32'h0000, 1'b0, 3'd0, 1'b1, 32'h00001234, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 5'd6,  1'b1, 32'h0,    D, 32'h1003, 1'b1, 3'd0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd7,  1'b1, 32'h0,    D, 32'h1002, 1'b1, 3'd4, 1'b1, 32'h000000FF, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 5'd8,  1'b1, 32'h0,    D, 32'h1002, 1'b1, 3'd1, 1'b1, 32'hFFFF80FF, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 5'd9,  1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd2, 1'b1, 32'h80FF7F01, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd10, 1'b1, 32'h0,    D, 32'h1002, 1'b1, 3'd2, 1'b0, D,            1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd11, 1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd3, 1'b0, D,            1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd0,  1'b1, 32'h55,   D, 32'h0000, 1'b0, 3'd0, 1'b0, 32'h00000055, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd12, 1'b1, 32'h0,    D, 32'h1001, 1'b1, 3'd5, 1'b0, D,            1'b1, 1'b0};
        vecs[9]  = '{1'b1, 5'd13, 1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd7, 1'b0, D,            1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd14, 1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd6, 1'b0, D,            1'b1, 1'b0};
        vecs[11] = '{1'b1, 5'd15, 1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd1, 1'b1, 32'h00007F01, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 5'd16, 1'b1, 32'h0,    D, 32'h1002, 1'b1, 3'd2, 1'b0, D,            1'b0, 1'b0};
        vecs[13] = '{1'b1, 5'd17, 1'b1, 32'h0,    D, 32'h1001, 1'b1, 3'd4, 1'b1, 32'h0000007F, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 5'd18, 1'b0, 32'hABCD, D, 32'h1003, 1'b0, 3'd7, 1'b0, 32'h0000ABCD, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 5'd19, 1'b1, 32'h0,    D, 32'h1002, 1'b1, 3'd5, 1'b1, 32'h000080FF, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 5'd20, 1'b1, 32'h0,    D, 32'h1000, 1'b1, 3'd1, 1'b1, 32'h00007F01, 1'b0, 1'b1};

        rst   = 1'b1;
        flush = 1'b0;
        stall = '0;
        randomize_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            randomize_inputs();
        end
        check_zero("reset");
        chk("reset.bubble_cnt", 64'(bubble_cnt_o), 64'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_vec(vecs[i]);
            tick();
            chk($sformatf("vec%0d.valid", i), 64'(valid_o), 64'(vecs[i].valid));
            chk($sformatf("vec%0d.rd_idx", i), 64'(rd_idx_o), 64'(vecs[i].rd));
            chk($sformatf("vec%0d.rd_we", i), 64'(rd_we_o), 64'(vecs[i].e_we));
            chk($sformatf("vec%0d.wb_data", i), 64'(wb_data_o), 64'(vecs[i].e_wb));
            chk($sformatf("vec%0d.mem_addr", i), 64'(mem_addr_o), 64'(vecs[i].addr));
            chk($sformatf("vec%0d.mem_re", i), 64'(mem_re_o), 64'(vecs[i].re));
            chk($sformatf("vec%0d.lderr", i), 64'(lderr_o), 64'(vecs[i].e_err));
            chk($sformatf("vec%0d.fwd_valid", i), 64'(fwd_valid_o), 64'(vecs[i].e_fwd));
        end

        // Bubble: stall bits 01 clear the stage and count
        apply_vec(vecs[0]);
        tick();
        stall[STAGE+1 -: 2] = 2'b01;
        tick();
        bubble_model();
        check_zero("bubble");
        chk("bubble.cnt1", 64'(bubble_cnt_o), 64'(cnt_exp));
        tick();
        bubble_model();
        chk("bubble.cnt2", 64'(bubble_cnt_o), 64'(cnt_exp));

        // Hold: stall bits 11 keep the stage for 4 cycles while inputs change
        stall = '0;
        apply_vec(vecs[1]);
        tick();
        stall[STAGE+1 -: 2] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            tick();
            chk($sformatf("hold%0d.wb_data", i), 64'(wb_data_o), 64'h0000_0000_FFFF_FF80);
            chk($sformatf("hold%0d.rd_idx", i), 64'(rd_idx_o), 64'd6);
            chk($sformatf("hold%0d.fwd_valid", i), 64'(fwd_valid_o), 64'd1);
            chk($sformatf("hold%0d.cnt", i), 64'(bubble_cnt_o), 64'(cnt_exp));
        end

        // Resume: stall bits 00 capture again
        stall = '0;
        apply_vec(vecs[4]);
        tick();
        chk("resume.wb_data", 64'(wb_data_o), 64'h0000_0000_80FF_7F01);
        chk("resume.rd_idx", 64'(rd_idx_o), 64'd9);

        // Flush beats bubble and is not counted
        flush = 1'b1;
        stall[STAGE+1 -: 2] = 2'b01;
        tick();
        check_zero("flush");
        chk("flush.cnt", 64'(bubble_cnt_o), 64'(cnt_exp));
        flush = 1'b0;
        stall = '0;

        // Asynchronous reset in the middle of a hold
        apply_vec(vecs[0]);
        tick();
        chk("prerst.wb_data", 64'(wb_data_o), 64'h1234);
        stall[STAGE+1 -: 2] = 2'b11;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cnt_exp = 0;
        check_zero("async_rst");
        chk("async_rst.cnt", 64'(bubble_cnt_o), 64'(cnt_exp));
        @(negedge clk);
        rst = 1'b0;
        stall = '0;
        apply_vec(vecs[4]);
        tick();
        chk("postrst.wb_data", 64'(wb_data_o), 64'h0000_0000_80FF_7F01);
        chk("postrst.valid", 64'(valid_o), 64'd1);

        // Saturation: 5 consecutive bubbles on a 2-bit counter
        stall[STAGE+1 -: 2] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            bubble_model();
            chk($sformatf("sat%0d.cnt", i), 64'(bubble_cnt_o), 64'(cnt_exp));
        end
        chk("sat.final", 64'(bubble_cnt_o), CNT_EN ? 64'd3 : 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cnt_exp = 0;
        chk("sat.rst", 64'(bubble_cnt_o), 64'(cnt_exp));
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mem_wb_stage.md
# riscv_mem_wb_stage

Parametrised MEM/WB pipeline register for the RISC-V core, sitting between the memory-access stage and register writeback. It latches the writeback control fields, applies stall/bubble/flush rules, and aligns and extends raw load data into a writeback value. It also flags misaligned or unsupported loads, exports a forwarding qualifier, and can optionally count inserted bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RD_W, 5, register index width.
- STALL_W, 6, width of the pipeline stall vector.
- STAGE, 3, index of this stage's stall bit; STAGE+1 must be < STALL_W.
- CNT_W, 32, bubble counter width.

Ports. Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall  in  STALL_W  pipeline stall vector
- flush  in  1  kill the instruction entering this stage
- valid_i  in  1  upstream slot holds a real instruction
- rd_idx_i  in  RD_W  destination register
- rd_we_i  in  1  register write enable
- alu_res_i  in  XLEN  non-load writeback value
- mem_data_i  in  XLEN  raw aligned memory word
- mem_addr_i  in  XLEN  load byte address
- mem_re_i  in  1  instruction is a load
- funct3_i  in  3  load size/sign code
- valid_o  out  1  registered valid
- rd_idx_o  out  RD_W  registered destination
- rd_we_o  out  1  qualified write enable
- wb_data_o  out  XLEN  formatted writeback value
- mem_addr_o  out  XLEN  registered address
- mem_re_o  out  1  registered load flag
- lderr_o  out  1  misaligned or unsupported load
- fwd_valid_o  out  1  combinational: valid_o & rd_we_o & (rd_idx_o != 0)
- bubble_cnt_o  out  CNT_W  bubbles inserted (see Configuration)

## Operation
Per clock, the register takes the first action that applies, in this priority order:
1. **rst**: clear all registers to 0.
2. **flush**: clear all registers to 0; this is not counted as a bubble.
3. **Bubble** (stall[STAGE] & !stall[STAGE+1]): clear all registers to 0 and increment the bubble counter.
4. **Load** (!stall[STAGE]): capture the formatted inputs.
5. **Hold** (stall[STAGE] & stall[STAGE+1]): keep all registers unchanged.

Load formatting uses off = mem_addr_i[log2(XLEN/8)-1:0]:
- 000 LB: byte at off, sign-extended.
- 100 LBU: byte at off, zero-extended.
- 001 LH: halfword at off, sign-extended; error if off[0] is set.
- 101 LHU: halfword at off, zero-extended; error if off[0] is set.
- 010 LW: word at off, sign-extended to XLEN; error if off[1:0] != 0.
- 110 LWU: word at off, zero-extended to XLEN; legal only when XLEN=64, otherwise an error.
- 011 LD: full word; legal only when XLEN=64 with off == 0, otherwise an error.
- 111: always an error.

Captured values on a Load action:
- wb_data_o <= mem_re_i ? formatted : alu_res_i. On a load error, wb_data_o is the raw mem_data_i.
- lderr_o <= valid_i & mem_re_i & err.
- rd_we_o <= valid_i & rd_we_i & (rd_idx_i != 0) & !(mem_re_i & err).
- valid_o <= valid_i; rd_idx_o, mem_addr_o and mem_re_o copy their inputs.
- Formatting is ignored when mem_re_i = 0, and lderr_o stays 0.

## Timing
- Latency is one cycle: inputs sampled at a posedge appear on the outputs after that edge.
- Reset value of every registered output is 0. fwd_valid_o is therefore 0 during reset, and bubble_cnt_o is 0.
- rst asserted mid-stall clears the stage immediately (asynchronously). The stage resumes at the first posedge after deassertion using the current stall vector.
- flush together with stall[STAGE]=1: flush wins and the stage clears.
- The bubble counter saturates at all-ones and is cleared only by rst.
- Consecutive bubble cycles each count: stall[STAGE]=1 for 3 cycles with stall[STAGE+1]=0 adds 3.

## Configuration
- Macro RISCV_MEMWB_BUBBLE_CNT_EN.
- Defined: a CNT_W-bit saturating counter increments on every Bubble action, and bubble_cnt_o drives the counter.
- Undefined: no counter flops are built and bubble_cnt_o is tied to 0. All other behaviour is identical.

## Test plan
- Reset sequence: with rst held and random inputs, every output reads 0. After rst drops, a load of rd_idx_i=5, rd_we_i=1, alu_res_i=0x1234, mem_re_i=0 gives rd_we_o=1 and wb_data_o=0x1234 one cycle later.
- Load formatting, mem_data_i=0x80FF7F01 at XLEN=32:
  - LB, addr 0x1003 -> wb_data_o=0xFFFFFF80.
  - LBU, addr 0x1002 -> 0x000000FF.
  - LH, addr 0x1002 -> 0xFFFF80FF.
  - LW, addr 0x1000 -> 0x80FF7F01.
- Errors: LW at addr 0x1002, or funct3=011 at XLEN=32 -> lderr_o=1, rd_we_o=0, wb_data_o=0x80FF7F01.
- Stall rules, stall bits [STAGE+1:STAGE]:
  - 01 -> zeros, and bubble_cnt_o increments when the macro is defined.
  - 11 -> outputs held for 4 cycles while the inputs change.
  - 00 -> capture resumes.
- Flush priority: flush=1 with stall=01 -> zeros and bubble_cnt_o unchanged. A write to rd_idx_i=0 gives rd_we_o=0 and fwd_valid_o=0.
- Counter saturation: with CNT_W=2, 5 consecutive bubble cycles -> bubble_cnt_o=3. Then rst -> 0.
